// File: rtl/uart_multi_channel.sv
// uart_multi_channel: multi-channel UART peripheral on the peripheral bus.
//
// Each channel has a TX FIFO, an RX FIFO, a programmable bit divider
// (bit period = divider+1 clocks), sticky error flags and a level interrupt.
// Register map per channel (channel = address[11:8], register = address[3:2]):
//   0 CONFIG  [15:0] divider (min 3), [16] enable, [17] rx irq en, [18] tx-empty irq en
//   1 STATUS  [7:0] rx count, [15:8] tx count, [16] rx ovf, [17] frame err, [18] tx ovf (W1C)
//   2 DATA    write pushes TX; read returns {valid, .., rx head} and pops on return
//
// Ports (top):
//   clk, rst                      clock, async active-low reset
//   peripheralBus_we/oe           write / read strobes
//   peripheralBus_busy            high on the first cycle of an accepted read
//   peripheralBus_address         24-bit byte address, [23:16] selects the block
//   peripheralBus_byteSelect      write byte lanes
//   peripheralBus_dataWrite/Read  write data / registered read data
//   requestOutput                 block is driving dataRead
//   uart_en, uart_rx, uart_tx     per-channel enable, serial in, serial out
//   irq                           per-channel level interrupt

// Simple synchronous FIFO. Push and pop in the same cycle on a full FIFO
// both succeed: the slot being written is the one being read out this cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// One UART channel: registers, both FIFOs, TX and RX state machines.
module uart_channel #(
    parameter int          DATA_BITS       = 8,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVIDER = 16'd103
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [3:0]  byte_sel,
    input  logic [31:0] wdata,
    input  logic        rx_pop,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        en_out,
    output logic        irq_out,
    output logic [31:0] rdata
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // configuration and flags
    logic [15:0] divider, div_m;
    logic        en, rxie, txie;
    logic        rx_ovf, ferr, tx_ovf;
    logic        cfg_wr, sts_wr, dat_wr;

    // FIFOs
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic                 rx_push, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic [CW-1:0]        tx_cnt, rx_cnt;

    // TX machine
    state_t               tx_state, tx_state_n;
    logic [15:0]          tx_tmr, tx_tmr_n, tx_div, tx_div_n;
    logic [BW-1:0]        tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_line, tx_bnd;

    // RX machine
    state_t               rx_state, rx_state_n;
    logic [15:0]          rx_tmr, rx_tmr_n, rx_div, rx_div_n;
    logic [BW-1:0]        rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_s1, rx_s2, rx_prev, rx_bnd, rx_smp, ferr_set;
    logic [16:0]          rx_half;

    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:19], byte_sel[3]};

    assign cfg_wr  = wr_en & (reg_sel == 2'd0);
    assign sts_wr  = wr_en & (reg_sel == 2'd1) & byte_sel[2];
    assign dat_wr  = wr_en & (reg_sel == 2'd2);
    assign tx_push = dat_wr & (byte_sel[0] | byte_sel[1]);

    // byte-merged divider, clamped so every bit has a usable mid-point
    always_comb begin
        div_m = divider;
        if (byte_sel[0]) div_m[7:0]  = wdata[7:0];
        if (byte_sel[1]) div_m[15:8] = wdata[15:8];
        if (div_m < 16'd3) div_m = 16'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= DEFAULT_DIVIDER;
            en      <= 1'b0;
            rxie    <= 1'b0;
            txie    <= 1'b0;
        end else if (cfg_wr) begin
            divider <= div_m;
            if (byte_sel[2]) begin
                en   <= wdata[16];
                rxie <= wdata[17];
                txie <= wdata[18];
            end
        end
    end

    // sticky flags: a new event in the clearing cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf <= 1'b0;
            ferr   <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_ovf <= (rx_ovf & ~(sts_wr & wdata[16])) | (rx_push & rx_full & ~rx_pop);
            ferr   <= (ferr   & ~(sts_wr & wdata[17])) | ferr_set;
            tx_ovf <= (tx_ovf & ~(sts_wr & wdata[18])) | (tx_push & tx_full & ~tx_pop);
        end
    end

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .din(wdata[DATA_BITS-1:0]),
        .pop(tx_pop), .dout(tx_head), .count(tx_cnt), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_shift),
        .pop(rx_pop), .dout(rx_head), .count(rx_cnt), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- TX ----------------
    // tx_div is reloaded at each bit boundary so divider writes land cleanly.
    assign tx_bnd = (tx_tmr == tx_div);

    always_comb begin
        tx_state_n = tx_state;
        tx_tmr_n   = tx_tmr + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        if (!en) begin
            tx_state_n = S_IDLE;
            tx_tmr_n   = '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_tmr_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                        tx_shift_n = tx_head;
                        tx_div_n   = divider;
                    end
                end
                S_START: if (tx_bnd) begin
                    tx_state_n = S_DATA;
                    tx_tmr_n   = '0;
                    tx_bit_n   = '0;
                    tx_div_n   = divider;
                end
                S_DATA: if (tx_bnd) begin
                    tx_tmr_n   = '0;
                    tx_div_n   = divider;
                    tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
                    if (tx_bit == BW'(DATA_BITS-1)) tx_state_n = S_STOP;
                    else                            tx_bit_n   = tx_bit + 1'b1;
                end
                S_STOP: if (tx_bnd) begin
                    tx_tmr_n = '0;
                    tx_div_n = divider;
                    // chain straight into the next frame when data is waiting
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                        tx_shift_n = tx_head;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end
                default: tx_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_tmr   <= '0;
            tx_div   <= DEFAULT_DIVIDER;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tmr   <= tx_tmr_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= (tx_state == S_START) ? 1'b0 :
                        (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;
        end
    end

    assign tx_out = tx_line | ~en;

    // ---------------- RX ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // The edge-detect cycle is bit position 0, so the timer enters START at 1.
    assign rx_half = (17'(rx_div) + 17'd1) >> 1;
    assign rx_smp  = (17'(rx_tmr) == rx_half);
    assign rx_bnd  = (rx_tmr == rx_div);

    always_comb begin
        rx_state_n = rx_state;
        rx_tmr_n   = rx_tmr + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        if (!en) begin
            rx_state_n = S_IDLE;
            rx_tmr_n   = '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_tmr_n = '0;
                    if (rx_prev & ~rx_s2) begin
                        rx_state_n = S_START;
                        rx_tmr_n   = 16'd1;
                        rx_div_n   = divider;
                    end
                end
                S_START: begin
                    if (rx_smp && rx_s2) begin
                        rx_state_n = S_IDLE;   // glitch, not a start bit
                    end else if (rx_bnd) begin
                        rx_state_n = S_DATA;
                        rx_tmr_n   = '0;
                        rx_bit_n   = '0;
                        rx_div_n   = divider;
                    end
                end
                S_DATA: begin
                    if (rx_smp) rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                    if (rx_bnd) begin
                        rx_tmr_n = '0;
                        rx_div_n = divider;
                        if (rx_bit == BW'(DATA_BITS-1)) rx_state_n = S_STOP;
                        else                            rx_bit_n   = rx_bit + 1'b1;
                    end
                end
                S_STOP: if (rx_smp) begin
                    // back to IDLE at the sample so the next start edge is seen
                    rx_state_n = S_IDLE;
                    rx_push    = rx_s2;
                    ferr_set   = ~rx_s2;
                end
                default: rx_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_tmr   <= '0;
            rx_div   <= DEFAULT_DIVIDER;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_tmr   <= rx_tmr_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // ---------------- readback / irq ----------------
    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = {13'd0, txie, rxie, en, divider};
            2'd1: rdata = {13'd0, tx_ovf, ferr, rx_ovf, 8'(tx_cnt), 8'(rx_cnt)};
            2'd2: rdata = {~rx_empty, {(31-DATA_BITS){1'b0}}, rx_head};
            default: rdata = '0;
        endcase
    end

    assign en_out  = en;
    assign irq_out = (rxie & ~rx_empty) | (txie & tx_empty & (tx_state == S_IDLE))
                   | rx_ovf | ferr | tx_ovf;
endmodule

module uart_multi_channel #(
    parameter logic [7:0]  ID              = 8'h00,
    parameter int          CHANNELS        = 4,
    parameter int          DATA_BITS       = 8,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVIDER = 16'd103
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                peripheralBus_we,
    input  logic                peripheralBus_oe,
    output logic                peripheralBus_busy,
    input  logic [23:0]         peripheralBus_address,
    input  logic [3:0]          peripheralBus_byteSelect,
    input  logic [31:0]         peripheralBus_dataWrite,
    output logic [31:0]         peripheralBus_dataRead,
    output logic                requestOutput,
    output logic [CHANNELS-1:0] uart_en,
    input  logic [CHANNELS-1:0] uart_rx,
    output logic [CHANNELS-1:0] uart_tx,
    output logic [CHANNELS-1:0] irq
);
    logic                       sel, wr, rd_start, rd_armed;
    logic                       req_q, rd_pop_q;
    logic [3:0]                 ch, rd_ch_q;
    logic [1:0]                 rsel;
    logic [31:0]                rd_mux, rd_data_q;
    logic [CHANNELS-1:0][31:0]  ch_rdata;

    logic unused_addr;
    assign unused_addr = ^{peripheralBus_address[15:12], peripheralBus_address[7:4],
                           peripheralBus_address[1:0]};

    assign sel  = (peripheralBus_address[23:16] == ID);
    assign ch   = peripheralBus_address[11:8];
    assign rsel = peripheralBus_address[3:2];
    assign wr   = sel & peripheralBus_we;

    // A read starts only from a fresh oe (rd_armed is set while oe is low);
    // a simultaneous write takes priority.
    assign rd_start = sel & peripheralBus_oe & ~peripheralBus_we & rd_armed & ~req_q;
    assign peripheralBus_busy     = rd_start;
    assign requestOutput          = req_q;
    assign peripheralBus_dataRead = req_q ? rd_data_q : '0;

    // channels at or above CHANNELS fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch == 4'(i)) rd_mux = ch_rdata[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_armed  <= 1'b0;
            req_q     <= 1'b0;
            rd_pop_q  <= 1'b0;
            rd_ch_q   <= '0;
            rd_data_q <= '0;
        end else begin
            req_q <= rd_start;
            if (rd_start)               rd_armed <= 1'b0;
            else if (!peripheralBus_oe) rd_armed <= 1'b1;
            if (rd_start) begin
                rd_data_q <= rd_mux;
                rd_ch_q   <= ch;
                rd_pop_q  <= (rsel == 2'd2) & rd_mux[31];
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        uart_channel #(
            .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIVIDER(DEFAULT_DIVIDER)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst),
            .wr_en    (wr & (ch == 4'(gi))),
            .reg_sel  (rsel),
            .byte_sel (peripheralBus_byteSelect),
            .wdata    (peripheralBus_dataWrite),
            .rx_pop   (req_q & rd_pop_q & (rd_ch_q == 4'(gi))),
            .rx_in    (uart_rx[gi]),
            .tx_out   (uart_tx[gi]),
            .en_out   (uart_en[gi]),
            .irq_out  (irq[gi]),
            .rdata    (ch_rdata[gi])
        );
    end
endmodule

// File: tb/tb_uart_multi_channel.sv
// Directed bench for uart_multi_channel: 4 channels, 8 data bits, 8-deep FIFOs,
// block ID 0x12. Channel 0 TX is looped back to channel 0 RX; channels 1..3 RX
// are driven directly.
module tb_uart_multi_channel;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, oe, busy, reqo;
    logic [23:0] addr;
    logic [3:0]  bs;
    logic [31:0] dw, dr;
    logic [3:0]  uart_en, uart_rx, uart_tx, irq, rx_drv;

    int checks = 0;
    int errors = 0;

    assign uart_rx = {rx_drv[3:1], uart_tx[0]};

    always #5 clk = ~clk;

    uart_multi_channel #(.ID(8'h12), .CHANNELS(4), .DATA_BITS(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .peripheralBus_we(we), .peripheralBus_oe(oe), .peripheralBus_busy(busy),
        .peripheralBus_address(addr), .peripheralBus_byteSelect(bs),
        .peripheralBus_dataWrite(dw), .peripheralBus_dataRead(dr),
        .requestOutput(reqo), .uart_en(uart_en), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .irq(irq)
    );

    function automatic logic [23:0] addr_of(input int ch, input int r);
        return {8'h12, 4'h0, 4'(ch), 4'h0, 2'(r), 2'b00};
    endfunction

    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        addr = addr_of(ch, r); dw = d; bs = 4'hF; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    // returns read data and the number of cycles busy was seen high
    task automatic bus_read(input int ch, input int r, output logic [31:0] d, output int bc);
        int n;
        @(negedge clk);
        addr = addr_of(ch, r); oe = 1'b1;
        #1;
        bc = 0; n = 0;
        while (!reqo && n < 8) begin
            if (busy) bc++;
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!reqo) begin
            errors++;
            $display("FAIL read_timeout ch=%0d reg=%0d requestOutput=0 want 1", ch, r);
        end
        d = dr;
        oe = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_rx3(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rx_drv[3] = bits[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk); rx_drv[3] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d; int bc;
        rst = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; bs = '0; dw = '0; rx_drv = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx !== 4'hF) begin errors++; $display("FAIL reset_tx got %h want f", uart_tx); end
        checks++; if (uart_en !== 4'h0) begin errors++; $display("FAIL reset_en got %h want 0", uart_en); end
        checks++; if (irq !== 4'h0) begin errors++; $display("FAIL reset_irq got %h want 0", irq); end
        checks++; if ({busy, reqo} !== 2'b00) begin errors++; $display("FAIL reset_busy_req got %b want 00", {busy, reqo}); end
        checks++; if (dr !== 32'h0) begin errors++; $display("FAIL reset_dataRead got %h want 0", dr); end
        bus_read(0, 0, d, bc);
        checks++; if (d !== 32'h0000_0067) begin errors++; $display("FAIL reset_config got %h want 00000067", d); end
        bus_read(0, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    endtask

    task automatic test_rx_empty();
        logic [31:0] d; int bc;
        bus_read(0, 2, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_data got %h want 0", d); end
        bus_read(0, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_status got %h want 0", d); end
    endtask

    task automatic test_loopback();
        logic [31:0] d; int bc;
        bus_write(0, 0, 32'h0001_0003);
        bus_write(0, 2, 32'h0000_00A5);
        @(negedge clk);
        checks++; if (uart_tx[0] !== 1'b1) begin errors++; $display("FAIL tx_latency_1 got %b want 1", uart_tx[0]); end
        @(negedge clk);
        checks++; if (uart_tx[0] !== 1'b0) begin errors++; $display("FAIL tx_latency_2 got %b want 0", uart_tx[0]); end
        repeat (60) @(negedge clk);
        bus_read(0, 1, d, bc);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL loop_status got %h want 00000001", d); end
        bus_read(0, 2, d, bc);
        checks++; if (d !== 32'h8000_00A5) begin errors++; $display("FAIL loop_data got %h want 800000a5", d); end
        checks++; if (bc != 1) begin errors++; $display("FAIL loop_busy_cycles got %0d want 1", bc); end
        bus_read(0, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL loop_pop got %h want 0", d); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d; int bc;
        for (int i = 0; i < 9; i++) bus_write(1, 2, 32'(i));
        bus_read(1, 1, d, bc);
        checks++; if (d !== 32'h0004_0800) begin errors++; $display("FAIL txovf_status got %h want 00040800", d); end
        checks++; if (irq[1] !== 1'b1) begin errors++; $display("FAIL txovf_irq got %b want 1", irq[1]); end
        bus_write(1, 1, 32'h0004_0000);
        bus_read(1, 1, d, bc);
        checks++; if (d !== 32'h0000_0800) begin errors++; $display("FAIL txovf_clear got %h want 00000800", d); end
        checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL txovf_irq_clear got %b want 0", irq[1]); end
    endtask

    task automatic test_isolation();
        logic [31:0] d; int bc; int low; int bad;
        bus_write(2, 0, 32'h0001_0001);
        bus_read(2, 0, d, bc);
        checks++; if (d !== 32'h0001_0003) begin errors++; $display("FAIL div_clamp got %h want 00010003", d); end
        checks++; if (uart_en !== 4'b0101) begin errors++; $display("FAIL uart_en got %b want 0101", uart_en); end
        bus_write(2, 2, 32'h0000_000F);
        low = 0; bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx[2] == 1'b0) low++;
            if ({uart_tx[3], uart_tx[1:0]} !== 3'b111) bad++;
        end
        checks++; if (low != 20) begin errors++; $display("FAIL frame_low_cycles got %0d want 20", low); end
        checks++; if (bad != 0) begin errors++; $display("FAIL other_tx_active got %0d want 0", bad); end
        bus_read(0, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL iso_ch0 got %h want 0", d); end
        bus_read(1, 1, d, bc);
        checks++; if (d !== 32'h0000_0800) begin errors++; $display("FAIL iso_ch1 got %h want 00000800", d); end
        bus_read(3, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL iso_ch3 got %h want 0", d); end
        bus_read(2, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL iso_ch2_done got %h want 0", d); end
        bus_write(5, 0, 32'h0001_0005);
        bus_read(5, 0, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ch5_read got %h want 0", d); end
    endtask

    task automatic test_frame_error();
        logic [31:0] d; int bc;
        bus_write(3, 0, 32'h0001_0003);
        drive_rx3(8'h3C, 1'b0);
        bus_read(3, 1, d, bc);
        checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL ferr_status got %h want 00020000", d); end
        checks++; if (irq[3] !== 1'b1) begin errors++; $display("FAIL ferr_irq got %b want 1", irq[3]); end
        drive_rx3(8'h5A, 1'b1);
        bus_read(3, 1, d, bc);
        checks++; if (d !== 32'h0002_0001) begin errors++; $display("FAIL rx_good_status got %h want 00020001", d); end
        bus_write(3, 1, 32'h0002_0000);
        bus_read(3, 1, d, bc);
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL ferr_clear got %h want 00000001", d); end
        bus_read(3, 2, d, bc);
        checks++; if (d !== 32'h8000_005A) begin errors++; $display("FAIL rx_good_data got %h want 8000005a", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d; int bc;
        bus_write(2, 2, 32'h0000_0000);
        repeat (10) @(negedge clk);
        checks++; if (uart_tx[2] !== 1'b0) begin errors++; $display("FAIL mid_frame_low got %b want 0", uart_tx[2]); end
        rst = 1'b0;
        #1;
        checks++; if (uart_tx !== 4'hF) begin errors++; $display("FAIL reset_async_tx got %h want f", uart_tx); end
        checks++; if (uart_en !== 4'h0) begin errors++; $display("FAIL reset_async_en got %h want 0", uart_en); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(2, 0, d, bc);
        checks++; if (d !== 32'h0000_0067) begin errors++; $display("FAIL rst2_config got %h want 00000067", d); end
        bus_read(1, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst2_ch1_status got %h want 0", d); end
        bus_read(3, 1, d, bc);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst2_ch3_status got %h want 0", d); end
        checks++; if (irq !== 4'h0) begin errors++; $display("FAIL rst2_irq got %h want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_rx_empty();
        test_loopback();
        test_tx_overflow();
        test_isolation();
        test_frame_error();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/uart_multi_channel.md
# uart_multi_channel

Parametrised multi-channel UART peripheral for the peripheral bus. Each channel has a TX FIFO, an RX FIFO, a programmable bit-rate divider, and overflow/frame-error flags. Unlike the fixed four-device UART, the block adds configurable channel count, data width and FIFO depth, a registered read path with a bus busy handshake, and per-channel interrupts. It attaches to the peripheral bus alongside other peripherals and drives the chip-level UART pins.

## Interface
- ID, 8'h00: peripheral ID; the block is selected when peripheralBus_address[23:16] == ID.
- CHANNELS, 4: channel count, 1..16.
- DATA_BITS, 8: frame data bits, 5..9.
- FIFO_DEPTH, 8: entries per FIFO, a power of two, 2..64.
- DEFAULT_DIVIDER, 16'd103: reset value of the divider field; bit period = divider+1 clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- peripheralBus_we  in  1  write strobe.
- peripheralBus_oe  in  1  read strobe.
- peripheralBus_busy  out  1  read in progress.
- peripheralBus_address  in  24  byte address.
- peripheralBus_byteSelect  in  4  write byte lanes.
- peripheralBus_dataWrite  in  32  write data.
- peripheralBus_dataRead  out  32  read data, valid while requestOutput=1.
- requestOutput  out  1  block is driving dataRead.
- uart_en  out  CHANNELS  per-channel enable (CONFIG bit 16).
- uart_rx  in  CHANNELS  serial inputs, asynchronous.
- uart_tx  out  CHANNELS  serial outputs, idle high.
- irq  out  CHANNELS  level interrupt per channel.

## Operation
- Address decode: channel = address[11:8]; register = address[3:2]. A channel number ≥ CHANNELS reads 0 and ignores writes.
- CONFIG (0x0, RW):
  - [15:0] divider, minimum 3; smaller values are clamped to 3.
  - [16] enable.
  - [17] RX interrupt enable; [18] TX-empty interrupt enable.
  - byteSelect masks bytes 0–2.
- STATUS (0x4):
  - [7:0] RX count; [15:8] TX count.
  - [16] RX overflow; [17] frame error; [18] TX overflow.
  - Bits [18:16] are write-1-to-clear. The other bits are RO.
- DATA (0x8):
  - Write (byte 0 or 1 selected) pushes dataWrite[DATA_BITS-1:0] into the TX FIFO.
  - Read returns [DATA_BITS-1:0] = RX head and [31] = valid. The RX FIFO pops on the data-return cycle only when valid=1.
- TX FIFO full:
  - A push is dropped and sets TX overflow.
  - RX full with a new frame arriving: the frame is dropped and RX overflow is set.
  - Push and pop on the same cycle on a full FIFO both succeed; count is unchanged.
- TX state machine: IDLE → START → DATA(DATA_BITS, LSB first) → STOP → IDLE.
  - Each state lasts divider+1 clocks.
  - It leaves IDLE only if enable=1 and the TX FIFO is not empty; the FIFO pops on entry to START.
- RX path: 2-flop synchroniser, then IDLE → START → DATA → STOP.
  - A falling edge in IDLE starts a frame; every sample is taken at (divider+1)/2 into the bit.
  - START sampled high: abort to IDLE, no flag set.
  - STOP sampled low: frame discarded and frame error set.
- enable=0:
  - Both state machines are forced to IDLE immediately and uart_tx=1.
  - FIFO contents are kept.
- irq = (rxIrqEn & RX count≠0) | (txIrqEn & TX count==0 & TX idle) | any STATUS error flag.
- peripheralBus_busy and requestOutput are for this block only.

## Timing
- Reset values:
  - uart_tx all 1; uart_en, irq, busy, requestOutput, dataRead all 0.
  - FIFOs empty, flags clear, divider = DEFAULT_DIVIDER, enable=0, both state machines IDLE.
- Write: single cycle (selected & we); busy stays 0; effects are visible the next cycle.
- Read handshake:
  - Cycle 1 (selected & oe, first cycle): busy=1, data is captured.
  - Cycle 2: busy=0, requestOutput=1, dataRead valid; the RX pop happens at the end of this cycle.
  - The master drops oe after busy falls; a new read needs oe to go low first.
  - If we and oe are both high, the write wins and no read starts.
- TX latency: uart_tx falls 2 clocks after a DATA write to an idle, enabled channel.
- Frame length: (DATA_BITS+2)·(divider+1) clocks.
- RX data is in the FIFO 1 clock after the STOP sample.
- Divider writes take effect at the next bit boundary.

## Test plan
- Reset: hold rst low mid-TX-frame, then release → uart_tx=1 immediately on assertion; all registers and FIFOs at reset values.
- Loopback (uart_tx[0] wired to uart_rx[0]): divider=3, enable, write 0xA5 → STATUS RX count=1; DATA read returns 0x800000A5; busy high for exactly 1 cycle.
- TX overflow (FIFO_DEPTH=8, enable=0): 9 DATA writes → TX count=8, TX overflow=1; write 1 to STATUS[18] clears it.
- Frame error: drive a frame with stop bit 0 → no FIFO entry; STATUS[17]=1; irq=1.
- RX empty read: DATA read with empty FIFO → 0x00000000, RX count stays 0.
- Channel isolation (CHANNELS=4): traffic on channel 2 leaves channels 0, 1 and 3 idle; an access to channel 5 reads 0.
